// File: rtl/banked_scratchpad_memory_pkg.sv
// Shared datapath constants for the PE scratchpad: word/opcode widths and the
// two memory opcodes the scratchpad responds to.
package banked_scratchpad_memory_pkg;

    localparam int TIA_WORD_WIDTH = 32;
    localparam int TIA_OP_WIDTH   = 5;

    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_NOP = 5'd0;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_LSW = 5'd20;
    localparam logic [TIA_OP_WIDTH-1:0] TIA_OP_SSW = 5'd21;

    function automatic logic is_mem_op(input logic [TIA_OP_WIDTH-1:0] op);
        return (op == TIA_OP_LSW) || (op == TIA_OP_SSW);
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Host MMIO bundle: a held read request with a registered ack, and a write
// request that is acked in the cycle it is accepted.
interface mmio_if
    import banked_scratchpad_memory_pkg::*;
#(
    parameter int INDEX_WIDTH = TIA_WORD_WIDTH,
    parameter int DATA_WIDTH  = TIA_WORD_WIDTH
) ();

    logic                   read_req;
    logic                   read_ack;
    logic [INDEX_WIDTH-1:0] read_index;
    logic [DATA_WIDTH-1:0]  read_data;
    logic                   write_req;
    logic                   write_ack;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [DATA_WIDTH-1:0]  write_data;

    modport device (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );

    modport host (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

endinterface

// File: rtl/single_port_ram.sv
// Single-port RAM bank with a registered read port; the output holds its value
// until the next read of this bank.
module single_port_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              enable,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  read_data
);

    // NOTE: storage has no reset so it maps onto RAM macros; contents survive reset.
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: non-blocking assignments keep every register update in the same edge order.
    always_ff @(posedge clock) begin
        if (enable) begin
            if (write_enable) begin
                mem[address] <= write_data;
            end else begin
                read_data <= mem[address];
            end
        end
    end

endmodule

// File: rtl/banked_scratchpad_memory.sv
// PE-private scratchpad over low-order-interleaved banks. Host MMIO and PE
// LSW/SSW share the banks; a host access wins a bank conflict and stalls the PE.
module banked_scratchpad_memory
    import banked_scratchpad_memory_pkg::*;
#(
    parameter int DEPTH            = 1024,
    parameter int NUM_BANKS        = 4,
    parameter int HOST_READ_ENABLE = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    mmio_if.device                    host_interface,
    input  logic [TIA_OP_WIDTH-1:0]   op,
    input  logic [TIA_WORD_WIDTH-1:0] operand_0,
    input  logic [TIA_WORD_WIDTH-1:0] operand_1,
    output logic                      stall,
    output logic [TIA_WORD_WIDTH-1:0] result,
    output logic                      result_valid
);

    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int BANK_W     = $clog2(NUM_BANKS);
    localparam int BANK_SEL_W = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROW_W      = ADDR_W - BANK_W;
    localparam int ROW_DEPTH  = DEPTH / NUM_BANKS;

    typedef enum logic [1:0] {HOST_IDLE, HOST_READ, HOST_ACK} host_state_t;

    host_state_t state_q, state_d;
    logic        host_rd_issue, host_wr_issue, host_issue;
    logic        read_ack, write_ack;

    logic [ADDR_W-1:0]     host_index, pe_index;
    logic [BANK_SEL_W-1:0] host_bank, pe_bank, host_bank_q, pe_bank_q;
    logic [ROW_W-1:0]      host_row, pe_row;
    logic                  pe_mem, pe_store, pe_go, pe_load;

    logic [TIA_WORD_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [TIA_WORD_WIDTH-1:0] read_data_q, result_q, load_data;
    logic                      result_valid_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        host_rd_issue = 1'b0;
        host_wr_issue = 1'b0;
        read_ack      = 1'b0;
        write_ack     = 1'b0;
        case (state_q)
            HOST_IDLE: begin
                if (host_interface.read_req) begin
                    state_d       = HOST_READ;
                    host_rd_issue = (HOST_READ_ENABLE != 0);
                end else if (host_interface.write_req) begin
                    host_wr_issue = 1'b1;
                    write_ack     = 1'b1;
                end
            end
            HOST_READ: state_d = HOST_ACK;
            HOST_ACK: begin
                read_ack = 1'b1;
                state_d  = HOST_IDLE;
            end
            default: state_d = HOST_IDLE;
        endcase
    end

    assign host_issue = host_rd_issue | host_wr_issue;

    // Upper address bits are dropped, so all addresses wrap modulo DEPTH.
    assign host_index = host_interface.read_req ? host_interface.read_index[ADDR_W-1:0]
                                                : host_interface.write_index[ADDR_W-1:0];
    assign host_bank  = BANK_SEL_W'(host_index & ADDR_W'(NUM_BANKS - 1));
    assign host_row   = host_index[ADDR_W-1:BANK_W];

    assign pe_mem   = is_mem_op(op);
    assign pe_store = (op == TIA_OP_SSW);
    assign pe_index = pe_store ? operand_1[ADDR_W-1:0] : operand_0[ADDR_W-1:0];
    assign pe_bank  = BANK_SEL_W'(pe_index & ADDR_W'(NUM_BANKS - 1));
    assign pe_row   = pe_index[ADDR_W-1:BANK_W];

    assign stall   = pe_mem && host_issue && (host_bank == pe_bank);
    assign pe_go   = pe_mem && !stall;
    assign pe_load = pe_go && !pe_store;

    // After stall resolution host and PE never hit the same bank, so the mux is safe.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic host_hit, pe_hit;
        assign host_hit = host_issue && (host_bank == BANK_SEL_W'(b));
        assign pe_hit   = pe_go && (pe_bank == BANK_SEL_W'(b));

        single_port_ram #(
            .WIDTH(TIA_WORD_WIDTH),
            .DEPTH(ROW_DEPTH)
        ) u_ram (
            .clock       (clock),
            .enable      (host_hit || pe_hit),
            .write_enable(host_hit ? host_wr_issue : pe_store),
            .address     (host_hit ? host_row : pe_row),
            .write_data  (host_hit ? host_interface.write_data : operand_0),
            .read_data   (bank_rdata[b])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= HOST_IDLE;
            host_bank_q    <= '0;
            read_data_q    <= '0;
            pe_bank_q      <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q <= state_d;
            if (host_rd_issue) host_bank_q <= host_bank;
            if (state_q == HOST_READ) begin
                read_data_q <= (HOST_READ_ENABLE != 0) ? bank_rdata[host_bank_q] : '0;
            end
            result_valid_q <= pe_load;
            if (pe_load) pe_bank_q <= pe_bank;
            if (result_valid_q) result_q <= load_data;
        end
    end

    // The bank output register is the load-data register; result_q only holds it afterwards.
    assign load_data    = bank_rdata[pe_bank_q];
    assign result       = result_valid_q ? load_data : result_q;
    assign result_valid = result_valid_q;

    assign host_interface.read_ack  = read_ack;
    assign host_interface.read_data = read_data_q;
    assign host_interface.write_ack = write_ack;

    logic unused_index_bits;
    assign unused_index_bits = ^{host_interface.read_index[TIA_WORD_WIDTH-1:ADDR_W],
                                 host_interface.write_index[TIA_WORD_WIDTH-1:ADDR_W],
                                 operand_1[TIA_WORD_WIDTH-1:ADDR_W]};

endmodule

// File: tb/tb_banked_scratchpad_memory.sv
// Directed bench for banked_scratchpad_memory: one instance with host reads
// enabled, one with them disabled, sharing clock and reset.
module tb_banked_scratchpad_memory;
    import banked_scratchpad_memory_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mmio_if mmio_a ();
    mmio_if mmio_b ();

    logic [TIA_OP_WIDTH-1:0]   op_a, op_b;
    logic [TIA_WORD_WIDTH-1:0] op0_a, op1_a, op0_b, op1_b;
    logic [TIA_WORD_WIDTH-1:0] result_a, result_b;
    logic                      stall_a, stall_b, rv_a, rv_b;

    banked_scratchpad_memory #(.DEPTH(1024), .NUM_BANKS(4), .HOST_READ_ENABLE(1)) dut (
        .clock(clock), .reset(reset), .host_interface(mmio_a),
        .op(op_a), .operand_0(op0_a), .operand_1(op1_a),
        .stall(stall_a), .result(result_a), .result_valid(rv_a)
    );

    banked_scratchpad_memory #(.DEPTH(1024), .NUM_BANKS(4), .HOST_READ_ENABLE(0)) dut_noread (
        .clock(clock), .reset(reset), .host_interface(mmio_b),
        .op(op_b), .operand_0(op0_b), .operand_1(op1_b),
        .stall(stall_b), .result(result_b), .result_valid(rv_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        mmio_a.read_req = 0; mmio_a.read_index = 0; mmio_a.write_req = 0;
        mmio_a.write_index = 0; mmio_a.write_data = 0;
        mmio_b.read_req = 0; mmio_b.read_index = 0; mmio_b.write_req = 0;
        mmio_b.write_index = 0; mmio_b.write_data = 0;
        op_a = TIA_OP_NOP; op0_a = 0; op1_a = 0;
        op_b = TIA_OP_NOP; op0_b = 0; op1_b = 0;

        tick(); tick();
        check("rst_result", result_a, 32'h0);
        check("rst_result_valid", rv_a, 1'b0);
        check("rst_read_ack", mmio_a.read_ack, 1'b0);
        check("rst_read_data", mmio_a.read_data, 32'h0);
        check("rst_stall", stall_a, 1'b0);
        check("rst_read_ack_noread", mmio_b.read_ack, 1'b0);
        reset = 0;

        // Host write @5, then host read @5 with a conflicting PE LSW @13 (bank 1).
        mmio_a.write_req = 1; mmio_a.write_index = 5; mmio_a.write_data = 32'hDEAD_BEEF;
        #1 check("idle_write_ack", mmio_a.write_ack, 1'b1);
        tick();
        mmio_a.write_req = 0; mmio_a.read_req = 1; mmio_a.read_index = 5;
        op_a = TIA_OP_LSW; op0_a = 13;
        #1 check("host_read_stalls_pe", stall_a, 1'b1);
        check("read_ack_req_cycle", mmio_a.read_ack, 1'b0);
        tick();
        op_a = TIA_OP_NOP;
        mmio_a.write_req = 1; mmio_a.write_index = 6; mmio_a.write_data = 32'h66;
        #1 check("stalled_lsw_no_valid", rv_a, 1'b0);
        check("read_ack_read_state", mmio_a.read_ack, 1'b0);
        check("write_ack_in_read", mmio_a.write_ack, 1'b0);
        tick();
        mmio_a.read_req = 0;
        #1 check("read_ack_2_cycles", mmio_a.read_ack, 1'b1);
        check("read_data_deadbeef", mmio_a.read_data, 32'hDEAD_BEEF);
        check("write_ack_in_ack", mmio_a.write_ack, 1'b0);
        tick();
        check("read_ack_one_cycle", mmio_a.read_ack, 1'b0);
        check("held_write_acked", mmio_a.write_ack, 1'b1);
        tick();
        mmio_a.write_req = 0;

        // PE store then load of the same address on consecutive cycles.
        op_a = TIA_OP_SSW; op0_a = 32'h1234; op1_a = 8;
        #1 check("ssw_no_stall", stall_a, 1'b0);
        tick();
        op_a = TIA_OP_LSW; op0_a = 8;
        tick();
        op_a = TIA_OP_NOP;
        check("raw_result_valid", rv_a, 1'b1);
        check("raw_result", result_a, 32'h1234);
        tick();
        check("result_valid_pulse", rv_a, 1'b0);
        check("result_holds", result_a, 32'h1234);

        op_a = TIA_OP_SSW; op0_a = 32'h9999; op1_a = 9;
        tick();

        // Same-bank conflict: host write @4 vs LSW @8 (both bank 0).
        op_a = TIA_OP_LSW; op0_a = 8;
        mmio_a.write_req = 1; mmio_a.write_index = 4; mmio_a.write_data = 32'hAAAA;
        #1 check("conflict_stall", stall_a, 1'b1);
        check("conflict_write_ack", mmio_a.write_ack, 1'b1);
        tick();
        mmio_a.write_req = 0;
        #1 check("reissue_no_stall", stall_a, 1'b0);
        check("stalled_no_valid", rv_a, 1'b0);
        tick();
        op_a = TIA_OP_NOP;
        check("reissue_valid", rv_a, 1'b1);
        check("reissue_result", result_a, 32'h1234);

        // Different banks: host write @4 and LSW @9 both complete.
        op_a = TIA_OP_LSW; op0_a = 9;
        mmio_a.write_req = 1; mmio_a.write_index = 4; mmio_a.write_data = 32'hBBBB;
        #1 check("diff_bank_no_stall", stall_a, 1'b0);
        tick();
        mmio_a.write_req = 0; op_a = TIA_OP_LSW; op0_a = 4;
        check("diff_bank_load", result_a, 32'h9999);
        tick();
        op_a = TIA_OP_NOP;
        check("diff_bank_host_write", result_a, 32'hBBBB);

        // A stalled store must not modify memory.
        op_a = TIA_OP_SSW; op0_a = 32'h5555; op1_a = 8;
        mmio_a.write_req = 1; mmio_a.write_index = 0; mmio_a.write_data = 32'h1;
        #1 check("stalled_ssw", stall_a, 1'b1);
        tick();
        mmio_a.write_req = 0; op_a = TIA_OP_LSW; op0_a = 8;
        tick();
        op_a = TIA_OP_NOP;
        check("stalled_ssw_no_effect", result_a, 32'h1234);

        // Address wrap: write @3, load @(DEPTH+3).
        mmio_a.write_req = 1; mmio_a.write_index = 3; mmio_a.write_data = 32'h77;
        tick();
        mmio_a.write_req = 0; op_a = TIA_OP_LSW; op0_a = 1027;
        tick();
        op_a = TIA_OP_NOP;
        check("wrap_result", result_a, 32'h77);

        // Back-to-back reads: read_req held through the ack starts a new read.
        mmio_a.read_req = 1; mmio_a.read_index = 6;
        tick(); tick();
        mmio_a.read_index = 3;
        check("read6_ack", mmio_a.read_ack, 1'b1);
        check("read6_data", mmio_a.read_data, 32'h66);
        tick();
        check("b2b_idle_no_ack", mmio_a.read_ack, 1'b0);
        tick();
        mmio_a.read_req = 0;
        tick();
        check("b2b_ack", mmio_a.read_ack, 1'b1);
        check("b2b_data", mmio_a.read_data, 32'h77);
        tick();

        // Reset while in HOST_READ aborts the ack; RAM contents survive.
        mmio_a.read_req = 1; mmio_a.read_index = 5;
        tick();
        mmio_a.read_req = 0; reset = 1;
        tick();
        reset = 0;
        check("abort_ack_a", mmio_a.read_ack, 1'b0);
        tick();
        check("abort_ack_b", mmio_a.read_ack, 1'b0);
        mmio_a.read_req = 1;
        tick(); tick();
        mmio_a.read_req = 0;
        check("ram_kept_ack", mmio_a.read_ack, 1'b1);
        check("ram_kept_data", mmio_a.read_data, 32'hDEAD_BEEF);
        tick();

        // Host reads disabled: same timing, zero data, no PE stall.
        mmio_b.write_req = 1; mmio_b.write_index = 3; mmio_b.write_data = 32'h77;
        #1 check("nr_write_ack", mmio_b.write_ack, 1'b1);
        tick();
        mmio_b.write_req = 0; mmio_b.read_req = 1; mmio_b.read_index = 3;
        op_b = TIA_OP_LSW; op0_b = 3;
        #1 check("nr_no_stall", stall_b, 1'b0);
        tick();
        op_b = TIA_OP_NOP;
        check("nr_pe_valid", rv_b, 1'b1);
        check("nr_pe_result", result_b, 32'h77);
        check("nr_read_state_ack", mmio_b.read_ack, 1'b0);
        tick();
        mmio_b.read_req = 0;
        check("nr_ack", mmio_b.read_ack, 1'b1);
        check("nr_data_zero", mmio_b.read_data, 32'h0);
        tick();
        check("nr_ack_done", mmio_b.read_ack, 1'b0);

        mmio_b.read_req = 1;
        tick();
        mmio_b.read_req = 0; reset = 1;
        tick();
        reset = 0;
        check("nr_abort_a", mmio_b.read_ack, 1'b0);
        tick();
        check("nr_abort_b", mmio_b.read_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
